// File: rtl/mdu_ctrl_if.sv
// EX/ID-side bus of the multiply/divide unit: op issue, hazard query and HI/LO readout.
interface mdu_ctrl_if;
  logic        ex_start;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        id_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output ex_start, ex_op, ex_a, ex_b, id_md,
                  input  busy, md_stall, hi, lo);
  modport slave  (input  ex_start, ex_op, ex_a, ex_b, id_md,
                  output busy, md_stall, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer with HI/LO registers. The result is computed at accept
// and held back for the configured latency, so timing matches a real iterative unit.
module mdu_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic   clk,
  input  logic   reset,
  mdu_ctrl_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        is_mul, is_div, accept, done;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

  assign is_mul = (md.ex_op == OP_MULT) || (md.ex_op == OP_MULTU);
  assign is_div = (md.ex_op == OP_DIV)  || (md.ex_op == OP_DIVU);
  assign accept = (state_q == S_IDLE) && md.ex_start;
  assign done   = (state_q != S_IDLE) && (cnt_q == 8'd0);

  // One shared magnitude divider; signs are folded back in afterwards.
  always_comb begin
    ext_a = (md.ex_op == OP_MULT) ? {{32{md.ex_a[31]}}, md.ex_a} : {32'd0, md.ex_a};
    ext_b = (md.ex_op == OP_MULT) ? {{32{md.ex_b[31]}}, md.ex_b} : {32'd0, md.ex_b};
    prod  = ext_a * ext_b;
    neg_a = (md.ex_op == OP_DIV) && md.ex_a[31];
    neg_b = (md.ex_op == OP_DIV) && md.ex_b[31];
    mag_a = neg_a ? 32'd0 - md.ex_a : md.ex_a;
    mag_b = neg_b ? 32'd0 - md.ex_b : md.ex_b;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq    = mag_a / div_b;
    ur    = mag_a % div_b;
    quo   = (neg_a ^ neg_b) ? 32'd0 - uq : uq;
    rem   = neg_a ? 32'd0 - ur : ur;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (md.ex_start) begin
        if (is_mul)      state_d = S_MUL;
        else if (is_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (cnt_q == 8'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    md.busy     = (state_q == S_MUL) || (state_q == S_DIV);
    md.md_stall = md.id_md && (md.busy || (md.ex_start && (md.ex_op <= OP_DIVU)));
    md.hi       = hi_q;
    md.lo       = lo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept && is_mul) begin
      p_hi_d = prod[63:32];
      p_lo_d = prod[31:0];
      cnt_d  = 8'(MULT_LAT - 1);
      dz_d   = 1'b0;
    end else if (accept && is_div) begin
      p_hi_d = rem;
      p_lo_d = quo;
      cnt_d  = 8'(DIV_LAT - 1);
      dz_d   = (md.ex_b == 32'd0);
    end else if ((state_q != S_IDLE) && (cnt_q != 8'd0)) begin
      cnt_d  = cnt_q - 8'd1;
    end
    if (accept && (md.ex_op == OP_MTHI)) hi_d = md.ex_a;
    if (accept && (md.ex_op == OP_MTLO)) lo_d = md.ex_a;
    // A divide by zero runs its full time but leaves HI/LO as they were.
    if (done && !dz_q) begin
      hi_d = p_hi_q;
      lo_d = p_lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 8'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
      dz_q   <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule
